// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB/BHT branch predictor.
// Branch codes outside BEQ..JR are treated as invalid and never train the table.
package branch_predictor_pkg;

    localparam int BP_ENTRIES_DEF = 16;

    localparam logic [3:0] BRANCH_CODE_DEFAULT = 4'd0;
    localparam logic [3:0] BRANCH_CODE_BEQ     = 4'd1;
    localparam logic [3:0] BRANCH_CODE_BNE     = 4'd2;
    localparam logic [3:0] BRANCH_CODE_BGE     = 4'd3;
    localparam logic [3:0] BRANCH_CODE_BGT     = 4'd4;
    localparam logic [3:0] BRANCH_CODE_BLE     = 4'd5;
    localparam logic [3:0] BRANCH_CODE_BLT     = 4'd6;
    localparam logic [3:0] BRANCH_CODE_JR      = 4'd7;

    typedef struct packed {
        logic       isBranch;
        logic [3:0] branchCode;
    } BranchType;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic logic code_trains(input logic [3:0] c);
        return (c >= BRANCH_CODE_BEQ) && (c <= BRANCH_CODE_JR);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, execute-resolve and statistics signals between pipeline and predictor.
// master = pipeline side, slave = predictor.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic [31:0] IF_PC;
    logic        IF_Valid;
    logic        Pred_Hit;
    logic        Pred_Taken;
    logic [31:0] Pred_Target;

    logic        EXE_Valid;
    BranchType   EXE_BranchType;
    logic [31:0] EXE_PC;
    logic        EXE_Taken;
    logic [31:0] EXE_Target;
    logic        EXE_PredTaken;
    logic [31:0] EXE_PredTarget;

    logic        Mispredict;
    logic [31:0] Redirect_PC;
    logic [31:0] Stat_Branches;
    logic [31:0] Stat_Mispredicts;

    modport master (
        output IF_PC, IF_Valid, EXE_Valid, EXE_BranchType, EXE_PC, EXE_Taken,
               EXE_Target, EXE_PredTaken, EXE_PredTarget,
        input  Pred_Hit, Pred_Taken, Pred_Target, Mispredict, Redirect_PC,
               Stat_Branches, Stat_Mispredicts
    );

    modport slave (
        input  IF_PC, IF_Valid, EXE_Valid, EXE_BranchType, EXE_PC, EXE_Taken,
               EXE_Target, EXE_PredTaken, EXE_PredTarget,
        output Pred_Hit, Pred_Taken, Pred_Target, Mispredict, Redirect_PC,
               Stat_Branches, Stat_Mispredicts
    );
endinterface

// File: rtl/branch_predictor_counter2.sv
// Saturating 2-bit taken/not-taken counter next-state logic.
module bp_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e cur,
    input  logic taken,
    output ctr_e next
);
    always_comb begin
        next = cur;
        if (taken) begin
            if (cur != ST) next = ctr_e'(cur + 2'd1);
        end else begin
            if (cur != SNT) next = ctr_e'(cur - 2'd1);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup, EXE-stage training,
// mispredict/redirect generation and saturating performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BP_ENTRIES = BP_ENTRIES_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    branch_predictor_if.slave  bus
);
    localparam int IDX_W = $clog2(BP_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    if (BP_ENTRIES < 4 || BP_ENTRIES > 64 || (1 << IDX_W) != BP_ENTRIES) begin : g_bad_entries
        $error("BP_ENTRIES must be a power of two in 4..64");
    end

    logic [BP_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag    [BP_ENTRIES];
    logic [31:0]           r_target [BP_ENTRIES];
    ctr_e                  r_ctr    [BP_ENTRIES];
    logic [31:0]           r_stat_br;
    logic [31:0]           r_stat_mp;

    logic [IDX_W-1:0] w_if_idx, w_ex_idx;
    logic [TAG_W-1:0] w_if_tag, w_ex_tag;
    logic             w_pred_hit, w_ex_hit, w_is_jr, w_upd, w_taken_eff, w_mispredict;
    ctr_e             w_ctr_next;
    logic             w_unused;

    assign w_unused = &{1'b0, bus.IF_PC[1:0]};

    assign w_if_idx = bus.IF_PC[IDX_W+1:2];
    assign w_if_tag = bus.IF_PC[31:IDX_W+2];
    assign w_ex_idx = bus.EXE_PC[IDX_W+1:2];
    assign w_ex_tag = bus.EXE_PC[31:IDX_W+2];

    // Lookup reads only stored state, so a same-cycle update is not visible here.
    assign w_pred_hit      = resetn && bus.IF_Valid && r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign bus.Pred_Hit    = w_pred_hit;
    assign bus.Pred_Taken  = w_pred_hit && r_ctr[w_if_idx][1];
    assign bus.Pred_Target = w_pred_hit ? r_target[w_if_idx] : 32'd0;

    assign w_is_jr     = (bus.EXE_BranchType.branchCode == BRANCH_CODE_JR);
    assign w_upd       = bus.EXE_Valid && bus.EXE_BranchType.isBranch &&
                         code_trains(bus.EXE_BranchType.branchCode);
    assign w_taken_eff = bus.EXE_Taken || w_is_jr;
    assign w_ex_hit    = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    bp_counter2 u_ctr (
        .cur   (r_ctr[w_ex_idx]),
        .taken (w_taken_eff),
        .next  (w_ctr_next)
    );

    assign w_mispredict    = resetn && w_upd &&
                             ((bus.EXE_Taken != bus.EXE_PredTaken) ||
                              (bus.EXE_Taken && (bus.EXE_Target != bus.EXE_PredTarget)));
    assign bus.Mispredict  = w_mispredict;
    // +8 skips the delay slot after a not-taken branch.
    assign bus.Redirect_PC = bus.EXE_Taken ? bus.EXE_Target : bus.EXE_PC + 32'd8;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= '0;
            for (int i = 0; i < BP_ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= WNT;
            end
        end else if (w_upd) begin
            if (w_ex_hit) begin
                r_ctr[w_ex_idx] <= w_ctr_next;
                if (w_taken_eff) r_target[w_ex_idx] <= bus.EXE_Target;
            end else if (w_taken_eff) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= bus.EXE_Target;
                r_ctr[w_ex_idx]    <= w_is_jr ? ST : WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else begin
            if (w_upd && r_stat_br != 32'hFFFF_FFFF)        r_stat_br <= r_stat_br + 32'd1;
            if (w_mispredict && r_stat_mp != 32'hFFFF_FFFF) r_stat_mp <= r_stat_mp + 32'd1;
        end
    end

    assign bus.Stat_Branches    = r_stat_br;
    assign bus.Stat_Mispredicts = r_stat_mp;
endmodule
